// File: rtl/tone_pkg.sv
// Shared constants, types and helpers for the square-wave tone generator.
// Half-period table is stored at 100 MHz and rescaled to the build clock.
package tone_pkg;

    localparam int unsigned CNT_W_DEF  = 20;
    localparam int unsigned CLK_HZ_DEF = 100_000_000;

    localparam logic [3:0] N_C  = 4'd0;
    localparam logic [3:0] N_CS = 4'd1;
    localparam logic [3:0] N_D  = 4'd2;
    localparam logic [3:0] N_DS = 4'd3;
    localparam logic [3:0] N_E  = 4'd4;
    localparam logic [3:0] N_F  = 4'd5;
    localparam logic [3:0] N_FS = 4'd6;
    localparam logic [3:0] N_G  = 4'd7;
    localparam logic [3:0] N_GS = 4'd8;
    localparam logic [3:0] N_A  = 4'd9;
    localparam logic [3:0] N_AS = 4'd10;
    localparam logic [3:0] N_B  = 4'd11;
    localparam logic [3:0] N_X  = 4'd12;

    localparam logic [2:0] H_MAX = 3'd4;

    // Octave-2 half periods in cycles of a 100 MHz clock.
    localparam int unsigned HALF_O2 [12] = '{
        764467, 721542, 681051, 642821, 606745, 572692,
        540546, 510209, 481575, 454545, 429034, 404954
    };

    typedef enum logic {
        SILENT = 1'b0,
        PLAY   = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] note;
        logic [2:0] oct;
    } tgt_t;

    localparam tgt_t TGT_REST = '{note: N_X, oct: 3'd2};

    function automatic longint unsigned half_at(
        input int              n,
        input longint unsigned clk_hz
    );
        if (n < 0 || n > 11) return 64'd0;
        return (64'(HALF_O2[n]) * clk_hz + 64'd50_000_000)
               / 64'd100_000_000;
    endfunction

    function automatic tgt_t classify(
        input logic       en,
        input logic [3:0] f,
        input logic [2:0] h
    );
        tgt_t t;
        t.note = (en && (f < N_X)) ? f : N_X;
        t.oct  = (h > H_MAX) ? H_MAX : h;
        return t;
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational note/octave to half-period lookup.
// Rest codes map to zero; the table is folded at elaboration.
module note_period_lut
    import tone_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
    input  logic [3:0]       note_i,
    input  logic [2:0]       h_eff_i,
    output logic [CNT_W-1:0] half_o
);

    logic [CNT_W-1:0] tbl [16];

    for (genvar i = 0; i < 16; i++) begin : g_tbl
        assign tbl[i] = CNT_W'(half_at(i, 64'(CLK_HZ)));
    end

    assign half_o = tbl[note_i] >> h_eff_i;

endmodule

// File: rtl/tone_gen.sv
// Glitch-free 50% square-wave tone generator with input qualification.
// Pitch changes and muting land only on full-period boundaries.
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] freq,
    input  logic [2:0] h,
    output logic       spk,
    output logic       playing,
    output logic       edge_tick
);

    logic [7:0]       in_q;
    logic [7:0]       live;
    logic             stable;
    tgt_t             tgt_live;
    tgt_t             tgt_q;
    tgt_t             tgt;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tgt_t             cur_q, cur_d;
    logic             spk_q, spk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] tgt_half;
    logic [CNT_W-1:0] cur_half;

    assign live     = {en, freq, h};
    assign stable   = (in_q == live);
    assign tgt_live = classify(en, freq, h);
    // Hold the last qualified target while the inputs are moving.
    assign tgt      = stable ? tgt_live : tgt_q;

    note_period_lut #(
        .CNT_W (CNT_W),
        .CLK_HZ(CLK_HZ)
    ) u_lut_tgt (
        .note_i (tgt.note),
        .h_eff_i(tgt.oct),
        .half_o (tgt_half)
    );

    note_period_lut #(
        .CNT_W (CNT_W),
        .CLK_HZ(CLK_HZ)
    ) u_lut_cur (
        .note_i (cur_q.note),
        .h_eff_i(cur_q.oct),
        .half_o (cur_half)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            tgt_q   <= TGT_REST;
            state_q <= SILENT;
            cnt_q   <= '0;
            cur_q   <= TGT_REST;
            spk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            in_q    <= live;
            tgt_q   <= tgt;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            spk_q   <= spk_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        spk_d   = spk_q;
        tick_d  = 1'b0;
        unique case (state_q)
            SILENT: begin
                spk_d = 1'b0;
                if (tgt.note != N_X) begin
                    cur_d   = tgt;
                    cnt_d   = tgt_half - CNT_W'(1);
                    spk_d   = 1'b1;
                    tick_d  = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    tick_d = 1'b1;
                    spk_d  = ~spk_q;
                    if (!spk_q) begin
                        cnt_d = cur_half - CNT_W'(1);
                    end else if (tgt.note == N_X) begin
                        cnt_d   = '0;
                        state_d = SILENT;
                    end else if (tgt != cur_q) begin
                        cur_d = tgt;
                        cnt_d = tgt_half - CNT_W'(1);
                    end else begin
                        cnt_d = cur_half - CNT_W'(1);
                    end
                end
            end
            default: state_d = SILENT;
        endcase
    end

    always_comb begin
        spk       = spk_q;
        playing   = (state_q == PLAY);
        edge_tick = tick_q;
    end

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen, built at a 1 MHz table scale.
// A monitor scores every spk level against queued expected lengths.
module tb_tone_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] freq;
    logic [2:0] h;
    logic       spk;
    logic       playing;
    logic       edge_tick;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic lvl;
        int   len;
    } run_t;

    typedef struct {
        logic       en;
        logic [3:0] f;
        logic [2:0] h;
        int         half;
        int         rmode;
    } vec_t;

    run_t sb[$];
    vec_t vt[7];

    // At 1 MHz, round(CLK/(2*f_oct2)) = 7645 7215 6811 6428 6067 5727
    // 5405 5102 4816 4545 4290 4050; shifted right by the octave.
    localparam int A2_HALF = 1136;
    localparam int C2_HALF = 1911;

    tone_gen #(
        .CNT_W (20),
        .CLK_HZ(1_000_000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .freq     (freq),
        .h        (h),
        .spk      (spk),
        .playing  (playing),
        .edge_tick(edge_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] f,
                         input logic [2:0] hh);
        en   = e;
        freq = f;
        h    = hh;
    endtask

    task automatic push(input logic l, input int n);
        run_t r;
        r.lvl = l;
        r.len = n;
        sb.push_back(r);
    endtask

    task automatic monitor();
        logic prev;
        int   run;
        run_t e;
        prev = 1'b0;
        run  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev = 1'b0;
                run  = 0;
            end else begin
                chk("edge_tick", edge_tick, spk != prev);
                if (spk != prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL toggle: level %0d ended after %0d, none expected",
                                 prev, run);
                    end else begin
                        e = sb.pop_front();
                        chk("run_level", prev, e.lvl);
                        if (e.len != 0) chk("run_len", run, e.len);
                    end
                    run = 1;
                end else begin
                    run++;
                end
                prev = spk;
            end
        end
    endtask

    task automatic wait_rise();
        int lat;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (spk) begin
                lat = i - 1;
                break;
            end
        end
        chk("rise_latency", lat, 2);
        chk("playing_on", playing, 1);
    endtask

    task automatic wait_fall(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!spk) break;
        end
        chk("fall_spk", spk, 0);
        chk("fall_playing", playing, 0);
    endtask

    task automatic go_rest(input int mode);
        case (mode)
            0:       freq = 4'd12;
            1:       freq = 4'd15;
            default: en   = 1'b0;
        endcase
    endtask

    task automatic idle_check(input int n);
        repeat (n) @(negedge clk);
        chk("idle_spk", spk, 0);
        chk("idle_playing", playing, 0);
    endtask

    task automatic run_vec(input vec_t v);
        push(1'b0, 0);
        push(1'b1, v.half);
        push(1'b0, v.half);
        push(1'b1, v.half);
        step(1);
        drive(v.en, v.f, v.h);
        wait_rise();
        step(2 * v.half + v.half / 2);
        go_rest(v.rmode);
        wait_fall(2 * v.half + 10);
        idle_check(40);
    endtask

    initial begin
        vt[0] = '{1'b1, 4'd9,  3'd2, 1136, 0};
        vt[1] = '{1'b1, 4'd0,  3'd0, 7645, 1};
        vt[2] = '{1'b1, 4'd11, 3'd4, 253,  2};
        vt[3] = '{1'b1, 4'd11, 3'd7, 253,  0};
        vt[4] = '{1'b1, 4'd5,  3'd3, 715,  1};
        vt[5] = '{1'b1, 4'd10, 3'd5, 268,  2};
        vt[6] = '{1'b1, 4'd7,  3'd3, 637,  0};

        rst_n = 1'b0;
        drive(1'b0, 4'd12, 3'd0);
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("reset_spk", spk, 0);
        chk("reset_playing", playing, 0);
        chk("reset_edge_tick", edge_tick, 0);
        step(1);
        rst_n = 1'b1;
        idle_check(5);

        foreach (vt[i]) run_vec(vt[i]);

        // A/h2 switched to C/h2 halfway through the first high phase.
        push(1'b0, 0);
        push(1'b1, A2_HALF);
        push(1'b0, C2_HALF);
        push(1'b1, C2_HALF);
        push(1'b0, C2_HALF);
        push(1'b1, C2_HALF);
        step(1);
        drive(1'b1, 4'd9, 3'd2);
        wait_rise();
        step(568);
        freq = 4'd0;
        step(7824 - 568);
        freq = 4'd12;
        wait_fall(2 * C2_HALF);
        idle_check(40);

        // One-cycle glitches and a short en drop never change pitch.
        push(1'b0, 0);
        push(1'b1, A2_HALF);
        push(1'b0, A2_HALF);
        push(1'b1, A2_HALF);
        push(1'b0, A2_HALF);
        push(1'b1, A2_HALF);
        step(1);
        drive(1'b1, 4'd9, 3'd2);
        wait_rise();
        step(500);
        freq = 4'd0;
        step(1);
        freq = 4'd9;
        step(299);
        en = 1'b0;
        step(10);
        en = 1'b1;
        step(3407 - 810);
        freq = 4'd0;
        step(1);
        freq = 4'd9;
        step(5112 - 3408);
        freq = 4'd12;
        wait_fall(2 * A2_HALF);
        idle_check(40);

        // Asynchronous reset in a high phase, then restart from SILENT.
        push(1'b0, 0);
        push(1'b1, A2_HALF);
        step(1);
        drive(1'b1, 4'd9, 3'd2);
        wait_rise();
        step(300);
        rst_n = 1'b0;
        #1;
        chk("arst_spk", spk, 0);
        chk("arst_playing", playing, 0);
        step(3);
        rst_n = 1'b1;
        push(1'b0, 0);
        push(1'b1, A2_HALF);
        push(1'b0, A2_HALF);
        push(1'b1, A2_HALF);
        wait_rise();
        step(2 * A2_HALF + 568);
        freq = 4'd12;
        wait_fall(2 * A2_HALF);
        idle_check(20);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream consumer of the tuner's note code (freq[3:0]) and octave index (h[2:0]).
- Drives the speaker pin with a glitch-free 50 % square wave at the selected pitch.
- Converts note + octave to a half-period count and runs a reload down-counter.
- Pitch changes and muting take effect only at full-period boundaries.

Parameters:
- CNT_W, 20, width of the half-period counter; must hold 764467.
- CLK_HZ, 100_000_000, clk frequency the period table is built for.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  1 = tone allowed; 0 = mute (finishes the current period)
- freq  in  4  note code: 0..11 = C..B, 12 = X (rest), 13..15 treated as rest
- h  in  3  octave index: 0..4 = octave 2..6; 5..7 clamp to 4
- spk  out  1  square-wave output
- playing  out  1  1 while state = PLAY
- edge_tick  out  1  one-cycle pulse on every spk toggle

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: spk=0, playing=0, edge_tick=0.
  - Internal: state=SILENT, cnt=0, cur_note=X, cur_h=2, in_r=0.
- Input qualification:
  - in_r <= {en, freq, h} every cycle.
  - Target is valid only when in_r equals the live inputs, i.e. stable for 2 consecutive cycles.
  - Single-cycle glitches are ignored; until the inputs are stable, the previous target is held.
- Target classification: rest if en=0 or freq>=12; otherwise a tone with h_eff = min(h,4).
- Period: half = LUT[note] >> h_eff, where LUT[n] = round(CLK_HZ / (2 * f_octave2[n])).
  - At 100 MHz: 764467, 721542, 681051, 642821, 606745, 572692, 540546, 510209, 481575, 454545, 429034, 404954.
  - Each spk level lasts exactly `half` cycles.
- FSM state SILENT:
  - spk=0.
  - When the target is a tone: latch cur_note/cur_h, cnt <= half-1, spk <= 1, go to PLAY.
  - Latency: input change at cycle n → stable at n+1 → spk=1 and playing=1 from n+2.
- FSM state PLAY:
  - While cnt != 0, cnt decrements each cycle.
  - When cnt==0: toggle spk, assert edge_tick for 1 cycle, then apply the rule for the toggle direction below.
  - 0→1 toggle: reload cnt with the current half-1; target changes are never applied here.
  - 1→0 toggle (full period done), target equals current: reload as normal.
  - 1→0 toggle, target is a different tone: latch the new note/octave, reload with the new half-1; the low phase uses the new half.
  - 1→0 toggle, target is rest: go to SILENT. playing falls in the same cycle as spk falls, and edge_tick still pulses.
- Simultaneous events: a target that becomes stable in the same cycle as the boundary is applied at that boundary.
- Same note with a different octave counts as a change.
- en=0 mid-tone: the current period completes, then the block goes SILENT. Re-asserting en before the boundary means no interruption.
- Reset mid-operation: spk drops immediately (async); on release the block restarts from SILENT.
- Width rules:
  - cnt is CNT_W unsigned.
  - The shift is a logical right shift and truncates.
  - No arithmetic overflow is possible.

Decomposition:
- tone_pkg holds:
  - note code constants C..B, X (0..12);
  - CLK_HZ and CNT_W defaults;
  - the 12-entry octave-2 half-period table;
  - state encodings SILENT / PLAY.
- Sub-module note_period_lut: combinational; takes (note[3:0], h_eff[2:0]) and returns half[CNT_W-1:0].
  - Returns 0 for rest codes; the FSM never loads 0.

Test Plan:
- Reset, then en=1, freq=9 (A), h=2, held:
  - spk rises 2 cycles after the input change;
  - high 113636 cycles, then low 113636 cycles, repeating;
  - edge_tick pulses at every toggle; playing=1.
- freq=0, h=0 → half-period 764467. freq=11, h=4 → half-period 25309. h=7 with freq=11 → identical to h=4.
- Playing A/h=2, switch to C/h=2 mid high phase:
  - the old high phase completes at 113636;
  - the low phase and all later phases are 191116 cycles;
  - no spk level shorter than 113636.
- Playing, set freq=12 (then repeat with freq=15 and with en=0):
  - the current period finishes;
  - spk=0 and playing=0 from the falling edge;
  - no further edge_tick.
- freq pulsed to a different note for 1 cycle during play → no pitch change at any boundary.
- rst_n asserted while spk=1 → spk=0 and playing=0 in the same cycle. After release with A/h=2 held → spk=1 two cycles later.
